hs_sync_rx: RTL and testbench

Destination-side endpoint of the four-phase req/ack handshake used to move a multi-bit word from a slow or unrelated clock domain into the `clk_dst` domain. Synchronizes the incoming level request, captures the source-held data bus, presents it downstream on a valid/ready interface, and returns a level acknowledge to the source. The source end holds `data_async` stable from `req_async` rise until `ack` rises. All logic runs on `clk_dst` except the asynchronous `req_async`/`data_async` inputs.

---
 rtl/cdc_pkg.sv | 19 +
 rtl/cdc_sync_bit.sv | 34 +++
 rtl/gnrl_dffr.sv | 25 ++
 rtl/hs_sync_rx.sv | 104 ++++++++++
 tb/tb_hs_sync_rx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the req/ack clock-domain-crossing endpoints.
//   hs_state_e      : 2-bit state encoding of the receive-side handshake FSM
//   SYNC_STAGES_MIN : smallest legal request synchronizer depth
//   SYNC_STAGES_MAX : largest legal request synchronizer depth
// -----------------------------------------------------------------------------
package cdc_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,  // waiting for a synchronized request
    HS_VALID    = 2'd1,  // word captured, offered downstream
    HS_WAIT_LOW = 2'd2   // ack high, waiting for the request to drop
  } hs_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// -----------------------------------------------------------------------------
// cdc_sync_bit
// Single-bit multi-flop synchronizer, every stage resets to 0.
//   clk   in  : destination clock
//   rst_n in  : asynchronous reset, active low
//   d     in  : asynchronous input level
//   q     out : d delayed by STAGES destination clock edges
// -----------------------------------------------------------------------------
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // chain[0] is the raw input, chain[STAGES] the fully settled output.
  logic [STAGES:0] chain;

  assign chain[0] = d;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    gnrl_dffr #(.DW(1)) u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (chain[g]),
      .q     (chain[g+1])
    );
  end

  assign q = chain[STAGES];

endmodule

// File: rtl/gnrl_dffr.sv
// -----------------------------------------------------------------------------
// gnrl_dffr
// Generic DW-bit D flop with asynchronous active-low reset to zero.
//   clk   in  : clock
//   rst_n in  : asynchronous reset, active low
//   d     in  : next value
//   q     out : registered value, 0 while in reset
// -----------------------------------------------------------------------------
module gnrl_dffr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/hs_sync_rx.sv
// -----------------------------------------------------------------------------
// hs_sync_rx
// Destination endpoint of a four-phase req/ack handshake. Synchronizes the
// request level, captures the source-held word, offers it downstream on a
// valid/ready interface and returns a level acknowledge.
//   clk_dst    in  : destination clock
//   rst_n_dst  in  : asynchronous reset, active low
//   req_async  in  : source request level (asynchronous)
//   data_async in  : source data, held stable while req is high and ack low
//   ack        out : acknowledge level back to the source (flop output)
//   dout       out : captured word
//   dout_valid out : dout holds an unconsumed word
//   dout_ready in  : downstream accepts dout when high together with dout_valid
//   busy       out : handshake in progress (FSM not idle)
//   proto_err  out : one-cycle pulse when the request drops before ack
//   xfer_cnt   out : completed transfers, wraps modulo 2^CW
// -----------------------------------------------------------------------------
module hs_sync_rx #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 16
) (
  input  logic          clk_dst,
  input  logic          rst_n_dst,
  input  logic          req_async,
  input  logic [DW-1:0] data_async,
  output logic          ack,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          proto_err,
  output logic [CW-1:0] xfer_cnt
);

  import cdc_pkg::*;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("hs_sync_rx: SYNC_STAGES out of range");
  end

  hs_state_e state;
  logic      req_sync;
  logic      err_seen;  // a violation was already flagged for the current word

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk_dst),
    .rst_n (rst_n_dst),
    .d     (req_async),
    .q     (req_sync)
  );

  // data_async is deliberately not synchronized bit by bit: the source holds it
  // stable from req rise until ack rise, so by the time req_sync is seen high
  // every data bit has long settled and a single wide capture is safe.
  always_ff @(posedge clk_dst or negedge rst_n_dst) begin
    if (!rst_n_dst) begin
      state      <= HS_IDLE;
      // NOTE: dout is a plain capture register, not a memory, so it is reset
      // like every other output to keep its post-reset value defined.
      dout       <= '0;
      dout_valid <= 1'b0;
      ack        <= 1'b0;
      proto_err  <= 1'b0;
      err_seen   <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      proto_err <= 1'b0;
      case (state)
        HS_IDLE: begin
          if (req_sync) begin
            dout       <= data_async;
            dout_valid <= 1'b1;
            err_seen   <= 1'b0;
            state      <= HS_VALID;
          end
        end
        HS_VALID: begin
          // Request dropped before ack: flag once, still deliver the word.
          if (!req_sync && !err_seen) begin
            proto_err <= 1'b1;
            err_seen  <= 1'b1;
          end
          if (dout_ready) begin
            dout_valid <= 1'b0;
            ack        <= 1'b1;
            state      <= HS_WAIT_LOW;
          end
        end
        HS_WAIT_LOW: begin
          if (!req_sync) begin
            ack      <= 1'b0;
            xfer_cnt <= xfer_cnt + CW'(1);
            state    <= HS_IDLE;
          end
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

  assign busy = (state != HS_IDLE);

endmodule

// File: tb/tb_hs_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_hs_sync_rx
// Self-checking bench for hs_sync_rx (DW=8, SYNC_STAGES=2, CW=8).
// A source-side driver performs the four-phase handshake and pushes each word
// into a scoreboard; a negedge monitor checks the outputs against the
// transaction-level rules every cycle.
// -----------------------------------------------------------------------------
module tb_hs_sync_rx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int CW = 8;

  logic          clk_dst = 1'b0;
  logic          rst_n_dst;
  logic          req_async;
  logic [DW-1:0] data_async;
  logic          ack;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          proto_err;
  logic [CW-1:0] xfer_cnt;

  hs_sync_rx #(.DW(DW), .SYNC_STAGES(SS), .CW(CW)) dut (
    .clk_dst    (clk_dst),
    .rst_n_dst  (rst_n_dst),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .proto_err  (proto_err),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk_dst = ~clk_dst;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];     // words sent by the source, in order
  int          model_cnt = 0; // completed handshakes seen since reset
  int          perr_cnt  = 0; // proto_err pulses seen
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic       prev_valid, prev_ack, prev_perr, pending_acc;
  logic [7:0] prev_dout;

  always @(negedge clk_dst) begin
    if (!rst_n_dst) begin
      prev_valid  = 1'b0;
      prev_ack    = 1'b0;
      prev_perr   = 1'b0;
      pending_acc = 1'b0;
      model_cnt   = 0;
      exp_q.delete();
    end else begin
      if (pending_acc) begin
        check("accept_ack_high", ack, 1'b1);
        check("accept_valid_low", dout_valid, 1'b0);
      end else if (prev_valid) begin
        check("hold_valid", dout_valid, 1'b1);
        check("hold_dout", dout, prev_dout);
      end
      check("ack_with_valid", ack & dout_valid, 1'b0);
      check("busy_level", busy, dout_valid | ack);
      if (prev_ack && !ack) model_cnt = (model_cnt + 1) % (1 << CW);
      check("xfer_cnt", xfer_cnt, model_cnt);
      if (proto_err) begin
        perr_cnt++;
        check("perr_one_cycle", prev_perr, 1'b0);
      end
      pending_acc = dout_valid & dout_ready;
      if (pending_acc) begin
        if (exp_q.size() == 0) check("sb_underflow", dout, 8'hxx);
        else                   check("sb_data", dout, exp_q.pop_front());
      end
      prev_valid = dout_valid;
      prev_ack   = ack;
      prev_perr  = proto_err;
      prev_dout  = dout;
    end
  end

  // Random backpressure, only while rand_ready is set.
  always @(posedge clk_dst) begin
    if (rand_ready) begin
      #1;
      dout_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------- driver
  // Counts edges (sampling #1 after each) until the chosen output reaches lvl.
  task automatic wait_sig(input bit sel_ack, input logic lvl, output int n);
    logic v;
    n = 0;
    do begin
      @(posedge clk_dst);
      #1;
      n++;
      v = sel_ack ? ack : dout_valid;
    end while (v !== lvl && n < 100);
    check(sel_ack ? "wait_ack" : "wait_valid", v, lvl);
  endtask

  // One four-phase transfer. bp: cycles of dout_ready=0 after capture;
  // early: drop req right after capture; exp_ack: expected edges from capture
  // to ack rise (-1 skips that check).
  task automatic send(input logic [7:0] d, input int bp, input bit early, input int exp_ack);
    int n;
    @(posedge clk_dst);
    #1;
    data_async = d;
    req_async  = 1'b1;
    exp_q.push_back(d);
    wait_sig(1'b0, 1'b1, n);
    check("capture_latency", n, SS + 1);
    check("capture_dout", dout, d);
    if (early) req_async = 1'b0;
    if (bp > 0) begin
      dout_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk_dst);
        #1;
        check("bp_valid", dout_valid, 1'b1);
        check("bp_ack", ack, 1'b0);
        check("bp_dout", dout, d);
      end
      dout_ready = 1'b1;
    end
    wait_sig(1'b1, 1'b1, n);
    if (exp_ack >= 0) check("ack_rise_latency", n + bp, exp_ack);
    if (!early) begin
      req_async = 1'b0;
      wait_sig(1'b1, 1'b0, n);
      check("ack_fall_latency", n, SS + 1);
    end else begin
      wait_sig(1'b1, 1'b0, n);
    end
  endtask

  task automatic do_reset();
    rst_n_dst = 1'b0;
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", xfer_cnt, 8'd0);
    check("rst_dout", dout, 8'd0);
    check("rst_perr", proto_err, 1'b0);
    repeat (2) @(posedge clk_dst);
    #1;
    rst_n_dst = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n, p0;
    req_async  = 1'b0;
    data_async = '0;
    dout_ready = 1'b1;
    do_reset();
    repeat (2) @(posedge clk_dst);

    // Single transfer, ready tied high: ack one edge after capture.
    send(8'hA5, 0, 1'b0, 1);
    check("t1_dout", dout, 8'hA5);
    check("t1_cnt", xfer_cnt, 8'd1);

    // Backpressure: 10 cycles of ready low, ack on the edge after ready rises.
    send(8'h3C, 10, 1'b0, 11);
    check("t2_dout", dout, 8'h3C);
    check("t2_cnt", xfer_cnt, 8'd2);

    // Early request drop while VALID: one proto_err pulse, word still delivered.
    p0 = perr_cnt;
    send(8'h5A, 4, 1'b1, 5);
    repeat (2) @(posedge clk_dst);
    #1;
    check("t3_perr_pulses", perr_cnt - p0, 1);
    check("t3_cnt", xfer_cnt, 8'd3);
    check("t3_busy", busy, 1'b0);

    // Reset while in WAIT_LOW with ack high, request still high afterwards.
    @(posedge clk_dst);
    #1;
    data_async = 8'hD2;
    req_async  = 1'b1;
    exp_q.push_back(8'hD2);
    wait_sig(1'b0, 1'b1, n);
    wait_sig(1'b1, 1'b1, n);
    check("t4_ack_before_rst", ack, 1'b1);
    #2;
    do_reset();
    exp_q.push_back(8'hD2);
    wait_sig(1'b0, 1'b1, n);
    check("t4_recapture_latency", n, SS + 1);
    check("t4_recapture_dout", dout, 8'hD2);
    wait_sig(1'b1, 1'b1, n);
    req_async = 1'b0;
    wait_sig(1'b1, 1'b0, n);
    check("t4_cnt", xfer_cnt, 8'd1);

    // 300 back-to-back transfers with random backpressure; counter wraps.
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 0, 1'b0, -1);
    end
    rand_ready = 1'b0;
    @(posedge clk_dst);
    #1;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk_dst);
    #1;
    check("rand_cnt_wrap", xfer_cnt, 8'd44);
    check("rand_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
